// File: rtl/ram_sched_pkg.sv
// Shared encodings for the feature-RAM address scheduler: FSM states, mux
// select codes, requester indices and small one-hot helpers.
package ram_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Select code drives {Load, Image, Layer} of the 16-bit address mux.
    localparam logic [2:0] SEL_DEC  = 3'b100;
    localparam logic [2:0] SEL_FILE = 3'b110;
    localparam logic [2:0] SEL_LYR  = 3'b001;
    localparam logic [2:0] SEL_NONE = 3'b000;

    localparam logic [1:0] REQ_DEC  = 2'd0;
    localparam logic [1:0] REQ_FILE = 2'd1;
    localparam logic [1:0] REQ_LYR  = 2'd2;

    function automatic logic [2:0] sel_of(input logic [2:0] oh);
        case (oh)
            3'b001:  sel_of = SEL_DEC;
            3'b010:  sel_of = SEL_FILE;
            3'b100:  sel_of = SEL_LYR;
            default: sel_of = SEL_NONE;
        endcase
    endfunction

    // Round-robin successor of the requester just served.
    function automatic logic [1:0] ptr_after(input logic [2:0] oh);
        case (oh)
            3'b001:  ptr_after = REQ_FILE;
            3'b010:  ptr_after = REQ_LYR;
            default: ptr_after = REQ_DEC;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational 3-way round-robin pick: first asserted request at or after
// ptr in the order Dec -> File -> Lyr -> Dec, returned one-hot.
module rr_arbiter3
    import ram_sched_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt
);

    logic [1:0] first, second, third;

    always_comb begin
        first  = REQ_DEC;
        second = REQ_FILE;
        third  = REQ_LYR;
        case (ptr)
            REQ_FILE: begin
                first  = REQ_FILE;
                second = REQ_LYR;
                third  = REQ_DEC;
            end
            REQ_LYR: begin
                first  = REQ_LYR;
                second = REQ_DEC;
                third  = REQ_FILE;
            end
            default: ;
        endcase
    end

    always_comb begin
        gnt = 3'b000;
        if (req[first])
            gnt[first] = 1'b1;
        else if (req[second])
            gnt[second] = 1'b1;
        else if (req[third])
            gnt[third] = 1'b1;
    end

endmodule

// File: rtl/ram_addr_scheduler.sv
// Arbitrates the shared feature-RAM address path between decompressor, file
// loader and layer-input reader; issues burst addresses with RAM handshake.
module ram_addr_scheduler
    import ram_sched_pkg::*;
#(
    parameter int AW   = 16,
    parameter int NREQ = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          DecReq,
    input  logic [AW-1:0] DecBase,
    input  logic [AW-1:0] DecLen,
    input  logic          FileReq,
    input  logic [AW-1:0] FileBase,
    input  logic [AW-1:0] FileLen,
    input  logic          LyrReq,
    input  logic [AW-1:0] LyrBase,
    input  logic [AW-1:0] LyrLen,
    output logic          DecDone,
    output logic          FileDone,
    output logic          LyrDone,
    output logic          DecGrant,
    output logic          FileGrant,
    output logic          LyrGrant,
    output logic          Load,
    output logic          Image,
    output logic          Layer,
    output logic [AW-1:0] BurstAddr,
    output logic          RamValid,
    input  logic          RamReady,
    output logic          Busy
);

    state_t          state;
    logic [NREQ-1:0] req_vec;
    logic [NREQ-1:0] pick;
    logic [NREQ-1:0] owner;
    logic [NREQ-1:0] grant_r;
    logic [NREQ-1:0] done_r;
    logic [2:0]      sel_r;
    logic [1:0]      ptr;
    logic [AW-1:0]   addr;
    logic [AW-1:0]   remain;
    logic [AW-1:0]   pick_base;
    logic [AW-1:0]   pick_len;

    // Requester vector is indexed by REQ_DEC/REQ_FILE/REQ_LYR.
    assign req_vec = {LyrReq, FileReq, DecReq};

    rr_arbiter3 u_arb (
        .req (req_vec),
        .ptr (ptr),
        .gnt (pick)
    );

    always_comb begin
        pick_base = DecBase;
        pick_len  = DecLen;
        if (pick[REQ_FILE]) begin
            pick_base = FileBase;
            pick_len  = FileLen;
        end else if (pick[REQ_LYR]) begin
            pick_base = LyrBase;
            pick_len  = LyrLen;
        end
    end

    assign {Load, Image, Layer} = sel_r;
    assign DecGrant  = grant_r[REQ_DEC];
    assign FileGrant = grant_r[REQ_FILE];
    assign LyrGrant  = grant_r[REQ_LYR];
    assign DecDone   = done_r[REQ_DEC];
    assign FileDone  = done_r[REQ_FILE];
    assign LyrDone   = done_r[REQ_LYR];
    assign BurstAddr = addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= REQ_DEC;
            owner    <= '0;
            grant_r  <= '0;
            done_r   <= '0;
            sel_r    <= SEL_NONE;
            addr     <= '0;
            remain   <= '0;
            RamValid <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            done_r <= '0;
            case (state)
                IDLE: begin
                    if (|req_vec) begin
                        owner  <= pick;
                        addr   <= pick_base;
                        remain <= pick_len;
                        Busy   <= 1'b1;
                        // A zero-length burst issues no beats: straight to the Done cycle.
                        if (pick_len == '0) begin
                            state  <= DONE;
                            done_r <= pick;
                        end else begin
                            state    <= BURST;
                            grant_r  <= pick;
                            sel_r    <= sel_of(pick);
                            RamValid <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (RamReady) begin
                        addr   <= addr + AW'(1);
                        remain <= remain - AW'(1);
                        if (remain == AW'(1)) begin
                            state    <= DONE;
                            done_r   <= owner;
                            grant_r  <= '0;
                            sel_r    <= SEL_NONE;
                            RamValid <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ptr   <= ptr_after(owner);
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_addr_scheduler.sv
// Directed bench for ram_addr_scheduler: reset, single burst, backpressure,
// zero-length, fairness, address wrap and reset mid-burst.
module tb_ram_addr_scheduler;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          DecReq, FileReq, LyrReq;
    logic [AW-1:0] DecBase, DecLen, FileBase, FileLen, LyrBase, LyrLen;
    logic          DecDone, FileDone, LyrDone;
    logic          DecGrant, FileGrant, LyrGrant;
    logic          Load, Image, Layer;
    logic [AW-1:0] BurstAddr;
    logic          RamValid, RamReady, Busy;

    int errors = 0;
    int checks = 0;

    ram_addr_scheduler #(.AW(AW), .NREQ(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .DecReq    (DecReq),
        .DecBase   (DecBase),
        .DecLen    (DecLen),
        .FileReq   (FileReq),
        .FileBase  (FileBase),
        .FileLen   (FileLen),
        .LyrReq    (LyrReq),
        .LyrBase   (LyrBase),
        .LyrLen    (LyrLen),
        .DecDone   (DecDone),
        .FileDone  (FileDone),
        .LyrDone   (LyrDone),
        .DecGrant  (DecGrant),
        .FileGrant (FileGrant),
        .LyrGrant  (LyrGrant),
        .Load      (Load),
        .Image     (Image),
        .Layer     (Layer),
        .BurstAddr (BurstAddr),
        .RamValid  (RamValid),
        .RamReady  (RamReady),
        .Busy      (Busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Select, grant {Dec,File,Lyr}, done {Dec,File,Lyr}, RamValid, Busy.
    task automatic chk_out(input string tag, input logic [2:0] sel, input logic [2:0] gnt,
                           input logic [2:0] done, input logic valid, input logic busy);
        chk({tag, ".sel"},   {29'd0, Load, Image, Layer}, {29'd0, sel});
        chk({tag, ".gnt"},   {29'd0, DecGrant, FileGrant, LyrGrant}, {29'd0, gnt});
        chk({tag, ".done"},  {29'd0, DecDone, FileDone, LyrDone}, {29'd0, done});
        chk({tag, ".valid"}, {31'd0, RamValid}, {31'd0, valid});
        chk({tag, ".busy"},  {31'd0, Busy}, {31'd0, busy});
    endtask

    task automatic chk_addr(input string tag, input logic [AW-1:0] exp);
        chk({tag, ".addr"}, {16'd0, BurstAddr}, {16'd0, exp});
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    logic [2:0]    gnt_t  [3];
    logic [2:0]    sel_t  [3];
    logic [AW-1:0] base_t [3];

    initial begin
        gnt_t  = '{3'b100, 3'b010, 3'b001};
        sel_t  = '{3'b100, 3'b110, 3'b001};
        base_t = '{16'h0100, 16'h0300, 16'h0500};

        // Reset held with every requester asking.
        reset_n  = 1'b0;
        DecReq   = 1'b1; FileReq = 1'b1; LyrReq = 1'b1;
        DecBase  = 16'h0010; DecLen  = 16'd4;
        FileBase = 16'h0200; FileLen = 16'd3;
        LyrBase  = 16'h0500; LyrLen  = 16'd2;
        RamReady = 1'b1;
        step();
        step();
        chk_out("reset", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        chk_addr("reset", 16'h0000);

        // Release: Dec wins first, 4-beat burst from 0x0010.
        reset_n = 1'b1;
        step();
        chk_out("dec_grant", 3'b100, 3'b100, 3'b000, 1'b1, 1'b1);
        DecReq = 1'b0; FileReq = 1'b0; LyrReq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            chk_addr($sformatf("dec_beat%0d", i), 16'h0010 + 16'(i));
            chk($sformatf("dec_beat%0d.valid", i), {31'd0, RamValid}, 32'd1);
        end
        step();
        chk_out("dec_done", 3'b000, 3'b000, 3'b100, 1'b0, 1'b1);
        step();
        chk_out("dec_idle", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);

        // Backpressure on a 3-beat File burst; RamReady toggles every cycle.
        FileReq = 1'b1; FileBase = 16'h0200; FileLen = 16'd3; RamReady = 1'b0;
        step();
        FileReq = 1'b0;
        chk_out("file_grant", 3'b110, 3'b010, 3'b000, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            chk_addr($sformatf("file_bp%0d", k), 16'h0200 + 16'(k / 2));
            chk($sformatf("file_bp%0d.valid", k), {31'd0, RamValid}, 32'd1);
            chk($sformatf("file_bp%0d.sel", k), {29'd0, Load, Image, Layer}, 32'h6);
            RamReady = 1'(k % 2);
        end
        step();
        chk_out("file_done", 3'b000, 3'b000, 3'b010, 1'b0, 1'b1);
        step();
        chk_out("file_idle", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);

        // Zero-length Lyr burst: Done in the cycle after the sample, no beats.
        RamReady = 1'b1;
        LyrReq = 1'b1; LyrLen = 16'd0;
        step();
        LyrReq = 1'b0;
        chk_out("lyr_zero_done", 3'b000, 3'b000, 3'b001, 1'b0, 1'b1);
        step();
        chk_out("lyr_zero_idle", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);

        // Fairness: all requesters held high, 2 beats each; pointer is at Dec.
        DecBase = 16'h0100; FileBase = 16'h0300; LyrBase = 16'h0500;
        DecLen  = 16'd2;    FileLen  = 16'd2;    LyrLen  = 16'd2;
        DecReq  = 1'b1;     FileReq  = 1'b1;     LyrReq  = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step();
            chk_out($sformatf("rr%0d.b0", j), sel_t[j % 3], gnt_t[j % 3], 3'b000, 1'b1, 1'b1);
            chk_addr($sformatf("rr%0d.b0", j), base_t[j % 3]);
            step();
            chk_addr($sformatf("rr%0d.b1", j), base_t[j % 3] + 16'd1);
            chk($sformatf("rr%0d.b1.valid", j), {31'd0, RamValid}, 32'd1);
            step();
            chk_out($sformatf("rr%0d.done", j), 3'b000, 3'b000, gnt_t[j % 3], 1'b0, 1'b1);
            if (j == 5) begin
                DecReq = 1'b0; FileReq = 1'b0; LyrReq = 1'b0;
            end
            step();
            chk_out($sformatf("rr%0d.gap", j), 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        end

        // Address wrap at the top of the space.
        LyrReq = 1'b1; LyrBase = 16'hFFFE; LyrLen = 16'd3;
        step();
        LyrReq = 1'b0;
        chk_out("wrap_grant", 3'b001, 3'b001, 3'b000, 1'b1, 1'b1);
        chk_addr("wrap0", 16'hFFFE);
        step();
        chk_addr("wrap1", 16'hFFFF);
        step();
        chk_addr("wrap2", 16'h0000);
        chk("wrap2.valid", {31'd0, RamValid}, 32'd1);
        step();
        chk_out("wrap_done", 3'b000, 3'b000, 3'b001, 1'b0, 1'b1);
        step();

        // Reset after 3 accepted beats of an 8-beat Dec burst.
        DecReq = 1'b1; DecBase = 16'h0040; DecLen = 16'd8;
        step();
        chk_out("rst_mid_grant", 3'b100, 3'b100, 3'b000, 1'b1, 1'b1);
        chk_addr("rst_mid0", 16'h0040);
        step();
        step();
        step();
        chk_addr("rst_mid3", 16'h0043);
        reset_n = 1'b0;
        #1;
        chk_out("rst_mid_now", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        chk_addr("rst_mid_now", 16'h0000);
        step();
        chk_out("rst_mid_hold", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        reset_n = 1'b1;
        step();
        chk_out("rst_restart", 3'b100, 3'b100, 3'b000, 1'b1, 1'b1);
        chk_addr("rst_restart", 16'h0040);
        DecReq = 1'b0;
        step();
        chk_addr("rst_restart1", 16'h0041);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
